// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op scheduler: opcode constants in ALU mux-port
// order and the sequencer state encoding.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SHL  = 4'd2;
   localparam logic [3:0] OP_SHR  = 4'd3;
   localparam logic [3:0] OP_CMP  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_NAND = 4'd8;
   localparam logic [3:0] OP_NOR  = 4'd9;
   localparam logic [3:0] OP_XNOR = 4'd10;
   localparam logic [3:0] OP_INV  = 4'd11;
   localparam logic [3:0] OP_NEG  = 4'd12;
   localparam logic [3:0] OP_STO  = 4'd13;
   localparam logic [3:0] OP_SWP  = 4'd14;
   localparam logic [3:0] OP_LOAD = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/op_fifo.sv
// Synchronous command FIFO with occupancy output and a synchronous flush that
// also blocks any push or pop in the same cycle.
module op_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;

   assign full     = (r_level == (AW+1)'(DEPTH));
   assign empty    = (r_level == '0);
   assign w_push   = push && !full && !flush;
   assign w_pop    = pop && !empty && !flush;
   assign pop_data = r_mem[r_rd_ptr];
   assign level    = r_level;

   // NOTE: the storage array is deliberately left out of reset; entries are only read behind a non-zero level, and a reset-free array maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/alu_op_scheduler.sv
// Queues ALU opcodes and sequences them as sel + one-cycle exec strobe, settle, Y capture.
// Optional single-step mode (one op per rising edge of step) under ALU_OP_SCHEDULER_STEP_EN.
module alu_op_scheduler
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
`ifdef ALU_OP_SCHEDULER_STEP_EN
   input  logic                     step,
`endif
   input  logic                     cmd_valid,
   input  logic [3:0]               cmd_op,
   output logic                     cmd_ready,
   output logic [3:0]               alu_sel,
   output logic                     alu_exec,
   input  logic [7:0]               alu_y,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [7:0]               res_data,
   output logic [3:0]               res_op,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [3:0]      r_sel;
   logic [3:0]      r_res_op;
   logic [7:0]      r_res_data;
   logic            r_res_valid;
   logic            w_push;
   logic            w_pop;
   logic            w_capture;
   logic            w_release;
   logic            w_go;
   logic            w_full;
   logic            w_empty;
   logic [3:0]      w_head;

   // No full-bypass: a full FIFO refuses even when a pop lands in the same cycle.
   assign cmd_ready = !w_full && !flush;
   assign w_push    = cmd_valid && cmd_ready;

   op_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (w_push),
      .push_data (cmd_op),
      .pop       (w_pop),
      .pop_data  (w_head),
      .level     (level),
      .full      (w_full),
      .empty     (w_empty)
   );

`ifdef ALU_OP_SCHEDULER_STEP_EN
   logic r_step_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_step_d <= 1'b0;
      else       r_step_d <= step;
   end

   assign w_go = step && !r_step_d;
`else
   assign w_go = 1'b1;
`endif

   // NOTE: every combinational output gets a default before the case so no path leaves it unassigned and infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      w_release   = 1'b0;
      alu_exec    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty && !r_res_valid && w_go) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            alu_exec    = 1'b1;
            w_cnt_nxt   = CW'(SETTLE - 1);
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_HOLD;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         ST_HOLD: begin
            if (res_ready) begin
               w_release   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         w_state_nxt = ST_IDLE;
         w_pop       = 1'b0;
         w_capture   = 1'b0;
         alu_exec    = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_sel       <= '0;
         r_res_op    <= '0;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_pop) begin
            r_sel    <= w_head;
            r_res_op <= w_head;
         end
         if (w_capture) r_res_data <= alu_y;
         if (flush || w_release) r_res_valid <= 1'b0;
         else if (w_capture)     r_res_valid <= 1'b1;
      end
   end

   assign alu_sel   = r_sel;
   assign res_op    = r_res_op;
   assign res_data  = r_res_data;
   assign res_valid = r_res_valid;
   assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: the bench plays the ALU register stage
// and predicts results as the ALU function applied to queued opcodes in order.
module tb_alu_op_scheduler;
   import alu_pkg::*;

   localparam int DEPTH  = 4;
   localparam int SETTLE = 2;

   typedef struct {
      logic [3:0] op;
      logic [7:0] data;
      int         c;
   } res_t;

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic       flush     = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd_op    = 4'd0;
   logic       res_ready = 1'b0;
`ifdef ALU_OP_SCHEDULER_STEP_EN
   logic       step      = 1'b0;
`endif
   logic       cmd_ready;
   logic [3:0] alu_sel;
   logic       alu_exec;
   logic [7:0] alu_y;
   logic       res_valid;
   logic [7:0] res_data;
   logic [3:0] res_op;
   logic       busy;
   logic [$clog2(DEPTH):0] level;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         n_exec = 0;
   int         last_exec_cyc = 0;
   int         rr_mode = 0;
   logic [7:0] a_sw = 8'd0;
   logic [7:0] b_sw = 8'd0;
   logic [7:0] y_reg = 8'd0;
   logic [7:0] model_y = 8'd0;
   logic [3:0] model_q[$];
   res_t       got_q[$];

   alu_op_scheduler #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
`ifdef ALU_OP_SCHEDULER_STEP_EN
      .step      (step),
`endif
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_ready (cmd_ready),
      .alu_sel   (alu_sel),
      .alu_exec  (alu_exec),
      .alu_y     (alu_y),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_op    (res_op),
      .busy      (busy),
      .level     (level)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] y);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_CMP:  return (a < b) ? 8'd1 : 8'd0;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NAND: return ~(a & b);
         OP_NOR:  return ~(a | b);
         OP_XNOR: return ~(a ^ b);
         OP_INV:  return ~a;
         OP_NEG:  return 8'd0 - a;
         default: return y;
      endcase
   endfunction

   // Bench-side ALU register stage: Y updates on the exec strobe.
   always @(posedge clock) begin
      if (alu_exec) y_reg <= alu_fn(alu_sel, a_sw, b_sw, y_reg);
   end
   assign alu_y = y_reg;

   always @(posedge clock) begin
      #2;
      case (rr_mode)
         0:       res_ready = 1'b0;
         1:       res_ready = 1'b1;
         default: res_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clock) begin
      if (alu_exec) begin
         n_exec++;
         last_exec_cyc = cyc;
      end
      if (res_valid && res_ready) got_q.push_back('{op: res_op, data: res_data, c: cyc});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed timeout expected event", tag);
   endtask

   task automatic push_op(input logic [3:0] op);
      bit acc;
      acc = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         acc = cmd_ready;
         @(posedge clock);
         #1;
         if (acc) break;
      end
      cmd_valid = 1'b0;
      if (acc) model_q.push_back(op);
      else     timeout_fail("push");
   endtask

   task automatic get_res(output res_t r, output bit ok);
      ok = 1'b0;
      r  = '{op: 4'd0, data: 8'd0, c: 0};
      for (int i = 0; i < 300; i++) begin
         if (got_q.size() > 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (ok) r = got_q.pop_front();
      else    timeout_fail("result_wait");
   endtask

   task automatic expect_next(input string tag, output res_t r);
      bit         ok;
      logic [3:0] eop;
      get_res(r, ok);
      eop     = model_q.pop_front();
      model_y = alu_fn(eop, a_sw, b_sw, model_y);
      if (ok) begin
         check({tag, "_op"}, 32'(r.op), 32'(eop));
         check({tag, "_data"}, 32'(r.data), 32'(model_y));
      end
   endtask

   initial begin
      res_t       r1;
      res_t       r2;
      res_t       r3;
      int         e0;
      bit         seen;
      logic [3:0] op_tmp;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_alu_sel",   32'(alu_sel),   32'd0);
      check("rst_alu_exec",  32'(alu_exec),  32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data",  32'(res_data),  32'd0);
      check("rst_res_op",    32'(res_op),    32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_level",     32'(level),     32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

`ifndef ALU_OP_SCHEDULER_STEP_EN
      // Single ADD: one exec, SETTLE+1 latency, Y = 5 + 3.
      rr_mode = 1;
      a_sw = 8'h05;
      b_sw = 8'h03;
      repeat (2) @(posedge clock);
      #1;
      e0 = n_exec;
      push_op(OP_ADD);
      expect_next("t1", r1);
      check("t1_data_const", 32'(r1.data), 32'h08);
      check("t1_op_const",   32'(r1.op),   32'(OP_ADD));
      check("t1_latency",    32'(r1.c - last_exec_cyc), 32'(SETTLE + 1));
      repeat (5) @(posedge clock);
      #1;
      check("t1_exec_count", 32'(n_exec - e0), 32'd1);

      // Reset while the op sits in WAIT: the op is lost.
      push_op(OP_ADD);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (alu_exec) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) timeout_fail("t2_exec_wait");
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("t2_alu_exec", 32'(alu_exec),  32'd0);
      check("t2_res_valid", 32'(res_valid), 32'd0);
      check("t2_level",    32'(level),     32'd0);
      check("t2_busy",     32'(busy),      32'd0);
      op_tmp  = model_q.pop_front();
      model_y = alu_fn(op_tmp, a_sw, b_sw, model_y);
      e0 = n_exec;
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check("t2_no_result", 32'(got_q.size()), 32'd0);
      check("t2_no_exec",   32'(n_exec - e0), 32'd0);

      // Back-to-back logic ops, one result every SETTLE+3 cycles.
      a_sw = 8'hF0;
      b_sw = 8'h3C;
      push_op(OP_AND);
      push_op(OP_OR);
      push_op(OP_XOR);
      expect_next("t3a", r1);
      expect_next("t3b", r2);
      expect_next("t3c", r3);
      check("t3a_const", 32'(r1.data), 32'h30);
      check("t3b_const", 32'(r2.data), 32'hFC);
      check("t3c_const", 32'(r3.data), 32'hCC);
      check("t3_gap1", 32'(r2.c - r1.c), 32'(SETTLE + 3));
      check("t3_gap2", 32'(r3.c - r2.c), 32'(SETTLE + 3));

      // Consumer stalled: FIFO fills, first result holds, nothing else issues.
      rr_mode = 0;
      repeat (2) @(posedge clock);
      #1;
      a_sw = 8'($urandom);
      b_sw = 8'($urandom);
      e0 = n_exec;
      for (int i = 0; i < DEPTH + 1; i++) push_op(4'($urandom));
      cmd_valid = 1'b1;
      cmd_op    = 4'($urandom);
      repeat (4) @(negedge clock);
      check("t4_cmd_ready", 32'(cmd_ready), 32'd0);
      check("t4_level",     32'(level),     32'(DEPTH));
      check("t4_res_valid", 32'(res_valid), 32'd1);
      check("t4_res_op",    32'(res_op),    32'(model_q[0]));
      check("t4_one_exec",  32'(n_exec - e0), 32'd1);
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      rr_mode = 1;
      for (int i = 0; i < DEPTH + 1; i++) expect_next($sformatf("t4_drain%0d", i), r1);
      repeat (10) @(posedge clock);
      #1;
      check("t4_no_extra",   32'(got_q.size()), 32'd0);
      check("t4_exec_total", 32'(n_exec - e0), 32'(DEPTH + 1));
      check("t4_level_end",  32'(level), 32'd0);

      // Flush with three queued ops, one in WAIT and a simultaneous push.
      a_sw = 8'($urandom);
      b_sw = 8'($urandom);
      for (int i = 0; i < 4; i++) push_op(4'($urandom));
      check("t5_level_pre", 32'(level), 32'd3);
      flush     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = OP_NEG;
      @(negedge clock);
      check("t5_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clock);
      #1;
      check("t5_level",     32'(level),     32'd0);
      check("t5_res_valid", 32'(res_valid), 32'd0);
      check("t5_busy",      32'(busy),      32'd0);
      flush     = 1'b0;
      cmd_valid = 1'b0;
      op_tmp  = model_q.pop_front();
      model_y = alu_fn(op_tmp, a_sw, b_sw, model_y);
      model_q.delete();
      e0 = n_exec;
      repeat (10) @(posedge clock);
      #1;
      check("t5_no_result", 32'(got_q.size()), 32'd0);
      check("t5_no_exec",   32'(n_exec - e0), 32'd0);

      // Random ops with irregular issue gaps and a randomly stalling consumer.
      rr_mode = 2;
      a_sw = 8'($urandom);
      b_sw = 8'($urandom);
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
         end
         push_op(4'($urandom));
      end
      for (int i = 0; i < 12; i++) expect_next($sformatf("t6_%0d", i), r1);
      repeat (10) @(posedge clock);
      #1;
      check("t6_no_extra", 32'(got_q.size()), 32'd0);
`else
      // Single-step: one exec per rising edge of step.
      rr_mode = 1;
      a_sw = 8'h21;
      b_sw = 8'h0F;
      repeat (2) @(posedge clock);
      #1;
      e0 = n_exec;
      push_op(OP_ADD);
      push_op(OP_SUB);
      repeat (5) @(posedge clock);
      #1;
      check("st_no_exec", 32'(n_exec - e0), 32'd0);
      step = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      check("st_one_exec", 32'(n_exec - e0), 32'd1);
      step = 1'b0;
      @(posedge clock);
      #1;
      step = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      check("st_two_exec", 32'(n_exec - e0), 32'd2);
      step = 1'b0;
      expect_next("st_a", r1);
      expect_next("st_b", r2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
